// File: rtl/adc_pkg.sv
// Shared types and constants for the SAR ADC control slice.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } adc_state_e;

  localparam int unsigned ADC_RESOLUTION            = 12;
  localparam int unsigned ADC_SAMPLE_CYCLES_DEFAULT = 2;
  localparam logic [ADC_RESOLUTION-1:0] ADC_MIDSCALE = 12'h800;

endpackage

// File: rtl/adc_sar_register.sv
// SAR trial register: bit index plus keep-or-clear / set-next logic driving the DAC code.
module adc_sar_register
  import adc_pkg::*;
#(
  parameter int unsigned RESOLUTION = ADC_RESOLUTION
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  step,
  input  logic                  comp,
  output logic [RESOLUTION-1:0] dac_data,
  output logic [RESOLUTION-1:0] resolved,
  output logic                  last
);

  localparam int unsigned IW = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(RESOLUTION - 1);

  logic [IW-1:0]         idx;
  logic [RESOLUTION-1:0] trial_nxt;

  // resolved = current code with the bit under test decided; used for the final code too
  always_comb begin
    resolved      = dac_data;
    resolved[idx] = comp;
    trial_nxt     = resolved;
    if (idx != '0) begin
      trial_nxt[idx - IW'(1)] = 1'b1;
    end
  end

  assign last = (idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data <= '0;
      idx      <= TOP_IDX;
    end else if (clear) begin
      dac_data <= '0;
      idx      <= TOP_IDX;
    end else if (load) begin
      dac_data <= {1'b1, {(RESOLUTION-1){1'b0}}};
      idx      <= TOP_IDX;
    end else if (step) begin
      dac_data <= trial_nxt;
      if (idx != '0) begin
        idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_sar_control.sv
// SAR ADC controller: IDLE -> SAMPLE -> CONVERT -> DONE, one registered result per start.
// Optional 4x averaging when ADC_AVG4_EN is defined.
module adc_sar_control
  import adc_pkg::*;
#(
  parameter int unsigned RESOLUTION    = ADC_RESOLUTION,
  parameter int unsigned SAMPLE_CYCLES = ADC_SAMPLE_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  comp_i,
  output logic                  sample_o,
  output logic                  comp_en_o,
  output logic [RESOLUTION-1:0] dac_data_o,
  output logic                  busy_o,
  output logic [RESOLUTION-1:0] result_o,
  output logic                  valid_o
);

  adc_state_e            state, state_nxt;
  logic [3:0]            samp_cnt;
  logic                  sar_clear, sar_load, sar_step, sar_last;
  logic [RESOLUTION-1:0] sar_resolved, final_code;

`ifdef ADC_AVG4_EN
  logic [1:0]            conv_cnt;
  logic [RESOLUTION+1:0] acc, acc_sum, acc_round;

  assign acc_sum    = acc + {2'b00, sar_resolved};
  assign acc_round  = acc_sum + (RESOLUTION+2)'(2);
  assign final_code = acc_round[RESOLUTION+1:2];
`else
  assign final_code = sar_resolved;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_i) state_nxt = SAMPLE;
      SAMPLE:  if (samp_cnt == 4'(SAMPLE_CYCLES - 1)) state_nxt = CONVERT;
      CONVERT: begin
        if (sar_last) begin
`ifdef ADC_AVG4_EN
          state_nxt = (conv_cnt == 2'd3) ? DONE : SAMPLE;
`else
          state_nxt = DONE;
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    sar_clear = (state_nxt == IDLE) || (state_nxt == SAMPLE);
    sar_load  = (state == SAMPLE) && (state_nxt == CONVERT);
    sar_step  = (state == CONVERT);
  end

  // Outputs are loaded from the next-state decode so they flip together with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      samp_cnt  <= '0;
      sample_o  <= 1'b0;
      comp_en_o <= 1'b0;
      busy_o    <= 1'b0;
      valid_o   <= 1'b0;
      result_o  <= '0;
    end else begin
      state     <= state_nxt;
      samp_cnt  <= ((state == SAMPLE) && (state_nxt == SAMPLE)) ? samp_cnt + 4'd1 : '0;
      sample_o  <= (state_nxt == SAMPLE);
      comp_en_o <= (state_nxt == CONVERT);
      busy_o    <= (state_nxt != IDLE);
      valid_o   <= (state_nxt == DONE);
      if ((state == CONVERT) && (state_nxt == DONE)) begin
        result_o <= final_code;
      end
    end
  end

`ifdef ADC_AVG4_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_cnt <= '0;
      acc      <= '0;
    end else if ((state == CONVERT) && sar_last) begin
      if (state_nxt == DONE) begin
        conv_cnt <= '0;
        acc      <= '0;
      end else begin
        conv_cnt <= conv_cnt + 2'd1;
        acc      <= acc_sum;
      end
    end else if (state == IDLE) begin
      conv_cnt <= '0;
      acc      <= '0;
    end
  end
`endif

  adc_sar_register #(
    .RESOLUTION(RESOLUTION)
  ) u_sar (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (sar_clear),
    .load    (sar_load),
    .step    (sar_step),
    .comp    (comp_i),
    .dac_data(dac_data_o),
    .resolved(sar_resolved),
    .last    (sar_last)
  );

endmodule

// File: tb/tb_adc_sar_control.sv
// Scoreboard bench for adc_sar_control with an ideal comparator (comp = vin >= dac).
module tb_adc_sar_control;
  import adc_pkg::*;

  localparam int unsigned RES = 12;
  localparam int unsigned SC  = 2;
`ifdef ADC_AVG4_EN
  localparam int unsigned NCONV = 4;
`else
  localparam int unsigned NCONV = 1;
`endif
  localparam int unsigned LAT      = NCONV * (SC + RES);
  localparam int unsigned BUSY_PER = NCONV * (SC + RES) + 1;
  localparam int unsigned PERIOD   = LAT + 2;

  logic           clk, rst_n, start_i, comp_i;
  logic           sample_o, comp_en_o, busy_o, valid_o;
  logic [RES-1:0] dac_data_o, result_o;

  adc_sar_control #(
    .RESOLUTION   (RES),
    .SAMPLE_CYCLES(SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .comp_i    (comp_i),
    .sample_o  (sample_o),
    .comp_en_o (comp_en_o),
    .dac_data_o(dac_data_o),
    .busy_o    (busy_o),
    .result_o  (result_o),
    .valid_o   (valid_o)
  );

  typedef struct {
    int unsigned res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests, fails, cyc;
  int unsigned vin_arr[4];
  int unsigned burst_cnt, burst_base;
  int unsigned last_exp;
  logic        prev_sample;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ideal SAR resolves exactly vin; averaging rounds half up
  function automatic int unsigned model_result(input int unsigned v0, v1, v2, v3);
    if (NCONV == 4) return (v0 + v1 + v2 + v3 + 2) / 4;
    return v0;
  endfunction

  // Ideal comparator, updated away from the active edge; one vin per sample burst
  initial begin
    comp_i      = 1'b0;
    burst_cnt   = 0;
    prev_sample = 1'b0;
    forever begin
      @(negedge clk);
      if (sample_o && !prev_sample) burst_cnt++;
      prev_sample = sample_o;
      comp_i = (vin_arr[(burst_cnt - burst_base - 1) & 3] >= int'(dac_data_o));
    end
  end

  // Monitor: pops expectations on every valid strobe
  initial begin
    int unsigned samp_n, busy_n;
    logic        prev_valid;
    exp_t        e;
    samp_n = 0; busy_n = 0; prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        samp_n = 0; busy_n = 0; prev_valid = 1'b0;
      end else begin
        if (sample_o) samp_n++;
        if (busy_o) busy_n++;
        if (valid_o) begin
          check("valid_pulse_width", prev_valid ? 2 : 1, 1);
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got valid with result %0d, expected no valid (cycle %0d)",
                     result_o, cyc);
          end else begin
            e = sb.pop_front();
            check("result", result_o, e.res);
            check("latency", cyc - e.cyc, LAT);
            check("sample_cycles", samp_n, NCONV * SC);
            check("busy_cycles", busy_n, BUSY_PER);
          end
          samp_n = 0;
          busy_n = 0;
        end
        prev_valid = valid_o;
      end
    end
  end

  task automatic do_start(input int unsigned v0, v1, v2, v3, output int unsigned start_cyc);
    exp_t e;
    @(negedge clk);
    vin_arr    = '{v0, v1, v2, v3};
    burst_base = burst_cnt;
    start_i    = 1'b1;
    @(posedge clk);
    #1;
    start_i   = 1'b0;
    start_cyc = cyc;
    e.res     = model_result(v0, v1, v2, v3);
    e.cyc     = start_cyc;
    last_exp  = e.res;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0 && !busy_o) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL wait_idle_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_one(input int unsigned v);
    int unsigned n;
    do_start(v, v, v, v, n);
    wait_idle();
    check("result_hold", result_o, last_exp);
    check("idle_busy", busy_o, 0);
  endtask

  initial begin
    int unsigned n, v;
    tests = 0; fails = 0; last_exp = 0; burst_base = 0;
    vin_arr = '{0, 0, 0, 0};
    rst_n   = 1'b0;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sample", sample_o, 0);
    check("rst_comp_en", comp_en_o, 0);
    check("rst_dac", dac_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_result", result_o, 0);
    check("rst_valid", valid_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Midscale input: trial codes 0x800 then 0xC00
    do_start(2048, 2048, 2048, 2048, n);
    repeat (2) @(negedge clk);
    check("sample_before_convert", sample_o, 1);
    @(negedge clk);
    check("dac_first_trial", dac_data_o, ADC_MIDSCALE);
    check("comp_en_convert", comp_en_o, 1);
    check("sample_in_convert", sample_o, 0);
    @(negedge clk);
    check("dac_second_trial", dac_data_o, 12'hC00);
    wait_idle();
    check("result_hold", result_o, last_exp);

    foreach (vin_arr[i]) vin_arr[i] = 0;
    run_one(0);
    run_one(4095);
    run_one(1);
    run_one(4094);
    for (int i = 0; i < 6; i++) run_one($urandom_range(0, 4095));

    // Starts while busy must be ignored
    do_start(1234, 1234, 1234, 1234, n);
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (7) @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    check("ignored_start_busy", busy_o, 0);
    check("ignored_start_result", result_o, 1234);

    // start_i held high: back-to-back conversions every PERIOD cycles
    v = $urandom_range(0, 4095);
    @(negedge clk);
    vin_arr    = '{v, v, v, v};
    burst_base = burst_cnt;
    start_i    = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.res = v;
      e.cyc = n + k * PERIOD;
      sb.push_back(e);
    end
    last_exp = v;
    repeat (2 * PERIOD) @(posedge clk);
    #1 start_i = 1'b0;
    wait_idle();
    check("held_start_result", result_o, v);

    // Asynchronous reset in convert cycle 5 aborts the conversion
    do_start(3000, 3000, 3000, 3000, n);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_sample", sample_o, 0);
    check("abort_comp_en", comp_en_o, 0);
    check("abort_dac", dac_data_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_result", result_o, 0);
    check("abort_valid", valid_o, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_abort_idle", busy_o, 0);
    run_one(3000);

    // Per-conversion input variation (averaged when enabled)
    do_start(1000, 1001, 1001, 1002, n);
    wait_idle();
    check("vary_result_hold", result_o, model_result(1000, 1001, 1001, 1002));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_sar_control.md
Name: adc_sar_control

Overview:
Successive-approximation controller that generates the 12-bit DAC code consumed by adc_row_col_decoder (its `data` input) and resolves it bit by bit from the comparator decision. It runs sample -> convert -> done per conversion and returns the final code with a one-cycle valid strobe. It sits between the digital top level (start/result) and the capacitive DAC decoder plus the comparator.

Parameters:
RESOLUTION, 12, number of SAR bits; width of dac_data_o and result_o.
SAMPLE_CYCLES, 2, clock cycles sample_o is held high per conversion (legal range 1..15).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  conversion request; sampled on clk, accepted only in IDLE.
comp_i  input  1  comparator decision, must be stable before the rising edge ending each convert cycle; 1 = Vin >= DAC.
sample_o  output  1  input sampling switch enable.
comp_en_o  output  1  comparator enable; high in every convert cycle.
dac_data_o  output  RESOLUTION  trial code driven to adc_row_col_decoder.data.
busy_o  output  1  high in every state except IDLE.
result_o  output  RESOLUTION  last completed conversion; held until the next completion.
valid_o  output  1  one-cycle pulse, coincident with result_o update.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sample_o=0, comp_en_o=0, dac_data_o=0, busy_o=0, result_o=0, valid_o=0, bit index=RESOLUTION-1. Reset mid-conversion aborts immediately; no valid_o is produced.
- All outputs are registered; no combinational path from comp_i or start_i to any output.
- IDLE: outputs per reset except result_o, which is held. start_i=1 at an edge -> SAMPLE.
- SAMPLE: sample_o=1, dac_data_o=0, sample counter counts SAMPLE_CYCLES cycles -> CONVERT.
- On entering CONVERT: bit index = RESOLUTION-1, dac_data_o = 1<<(RESOLUTION-1), i.e. 12'h800.
- CONVERT, one bit per cycle, comp_en_o=1:
  - At the edge ending the cycle for bit i, the bit is kept if comp_i=1 and cleared if comp_i=0.
  - If i>0, bit i-1 is set in the same edge.
  - After bit 0 resolves -> DONE.
  - CONVERT lasts exactly RESOLUTION cycles.
- DONE (1 cycle): result_o = final code, valid_o=1, busy_o=1, comp_en_o=0, dac_data_o holds the final code -> IDLE unconditionally.
- Latency: start edge E0 -> valid_o high in the cycle following edge E0+SAMPLE_CYCLES+RESOLUTION; 14 cycles with defaults.
- start_i while busy: ignored, no queuing.
- start_i held high: a new conversion starts from IDLE on the next edge, so back-to-back period = SAMPLE_CYCLES+RESOLUTION+2 cycles.
- comp_i is ignored outside CONVERT.
- Boundaries:
  - comp_i always 1 -> result 4095.
  - comp_i always 0 -> result 0.
  - The code never exceeds 2^RESOLUTION-1; no wrap.

Optional Feature:
ADC_AVG4_EN.
- Defined: each accepted start runs 4 complete SAMPLE+CONVERT sequences back-to-back, with no IDLE and no DONE between them. Codes accumulate in an internal RESOLUTION+2 bit sum, and result_o = (sum+2)>>2 (round half up; max 16380 -> 4095, no overflow). valid_o pulses once after the 4th conversion. Latency becomes 4*(SAMPLE_CYCLES+RESOLUTION) edges to the DONE state. busy_o stays high throughout. Reset clears the accumulator and a conversion counter (0..3).
- Undefined: single conversion per start, exactly as described in Behaviour; no accumulator logic is synthesized.

Decomposition:
- Shared package adc_pkg holds:
  - the state enum IDLE/SAMPLE/CONVERT/DONE;
  - ADC_RESOLUTION=12 and ADC_SAMPLE_CYCLES_DEFAULT=2;
  - ADC_MIDSCALE=12'h800.
- One natural sub-module, adc_sar_register: holds the trial/decision shift logic (bit index, set-next/keep-or-clear) and dac_data_o. The FSM and counters stay in adc_sar_control.

Test Plan:
- Ideal comparator model comp_i=(vin>=dac_data_o), vin=2048: start pulse -> dac_data_o sequence starts 0x800, 0xC00, ...; result_o=2048, valid_o exactly 14 cycles after the start edge, single-cycle pulse.
- vin=0 -> result_o=0; vin=4095 -> result_o=4095; vin=1 -> result_o=1; vin=4094 -> result_o=4094. sample_o high exactly 2 cycles per conversion.
- start_i pulsed again at cycles 3 and 10 of a conversion (vin=1234) -> ignored; result_o=1234, one valid_o only. start_i held high -> conversions repeat every 16 cycles.
- rst_n low during convert cycle 5 (vin=3000) -> all outputs 0 immediately (async); after release no valid_o until a new start. The next conversion then gives result_o=3000.
- With ADC_AVG4_EN, vin toggling 1000, 1001, 1001, 1002 per conversion -> one valid_o after 56 cycles, result_o=1001 ((4004+2)>>2). Four sample_o bursts, busy_o continuous.
